// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with integer baud divider and single-byte holding.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int CLKDIV   = 868,
  parameter int STOPBITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txen,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_stop_idx;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
`ifdef UART_TX_PARITY_EN
  logic        r_par;
`endif

  logic w_bit_end;
  assign w_bit_end = (r_cnt == 16'(CLKDIV - 1));

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

  // tx is loaded at each state transition so the line level always matches the state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= '0;
          if (txen) begin
            r_shift <= din;
`ifdef UART_TX_PARITY_EN
            r_par   <= ^din;
`endif
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state    <= S_STOP;
              r_stop_idx <= 1'b0;
              r_tx       <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop_idx == 1'(STOPBITS - 1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and random frames against a bit-list frame model.
module tb_uart_tx;
  localparam int CLKDIV   = 4;
  localparam int STOPBITS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txen = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, tx, done;

  int n_checks = 0;
  int n_err    = 0;
  int busy_cycles = 0;

  uart_tx #(.CLKDIV(CLKDIV), .STOPBITS(STOPBITS)) dut (
    .clk  (clk),
    .rst  (rst),
    .txen (txen),
    .din  (din),
    .busy (busy),
    .tx   (tx),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] b, output bit bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(($countones(b) % 2) == 1);
`endif
    for (int i = 0; i < STOPBITS; i++) bits.push_back(1'b1);
  endfunction

  // Called in the first START cycle; returns in the cycle busy falls.
  task automatic check_frame(input string tag, input logic [7:0] b, input bit poke);
    bit bits[$];
    int frame_len;
    build_frame(b, bits);
    frame_len = bits.size() * CLKDIV;
    for (int i = 0; i < frame_len; i++) begin
      check({tag, "_tx"}, {31'd0, tx}, {31'd0, bits[i / CLKDIV]});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (busy === 1'b1) busy_cycles++;
      if (i % CLKDIV == 0) check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      txen = poke && (i == 10);
      din  = (poke && i == 10) ? 8'hFF : 8'($urandom);
      step();
    end
    txen = 1'b0;
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_tx_idle"}, {31'd0, tx}, 32'd1);
  endtask

  task automatic request(input logic [7:0] b);
    txen = 1'b1;
    din  = b;
    step();
    txen = 1'b0;
    din  = 8'($urandom);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_tx"}, {31'd0, tx}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      step();
    end
  endtask

  initial begin
    logic [7:0] rb;
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_check("reset", 20);

    // Single byte 'P'
    request(8'h50);
    check_frame("single", 8'h50, 1'b0);
    step();
    idle_check("after_single", 3);

    // Ignored request mid-frame
    request(8'h2C);
    check_frame("ignored", 8'h2C, 1'b1);
    step();
    idle_check("no_second", 2 * CLKDIV);

    // Back-to-back: new request in the done cycle
    busy_cycles = 0;
    request(8'h41);
    check_frame("b2b_a", 8'h41, 1'b0);
    request(8'h0A);
    check_frame("b2b_b", 8'h0A, 1'b0);
`ifdef UART_TX_PARITY_EN
    check("b2b_total", busy_cycles, 2 * (10 + STOPBITS) * CLKDIV);
`else
    check("b2b_total", busy_cycles, 2 * (9 + STOPBITS) * CLKDIV);
`endif
    step();
    idle_check("after_b2b", 2);

    // Mid-frame reset during data bit 3 of 0x00
    request(8'h00);
    for (int i = 0; i < (1 + 3) * CLKDIV + 1; i++) step();
    check("midrst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    request(8'h31);
    check_frame("post_rst", 8'h31, 1'b0);
    step();

    // rst and txen together: reset wins, byte discarded
    rst  = 1'b1;
    txen = 1'b1;
    din  = 8'h55;
    step();
    rst  = 1'b0;
    txen = 1'b0;
    idle_check("rst_txen", 3);

    // Parity-relevant bytes (plain frames in the default build)
    request(8'h07);
    check_frame("par07", 8'h07, 1'b0);
    step();
    request(8'h03);
    check_frame("par03", 8'h03, 1'b0);
    step();

    // Random bytes, randomly chained or separated
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      request(rb);
      check_frame("random", rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        step();
        idle_check("rand_gap", 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
